// File: rtl/theta_stage.sv
// Keccak theta step with a registered output and a 2-entry skid buffer.
// Theta is purely combinational on the input. The result is stored in OUT,
// or in SKID when OUT is still waiting for the downstream stage.

package keccak_pkg;
  localparam int ROW_SIZE  = 5;
  localparam int COL_SIZE  = 5;
  localparam int LANE_SIZE = 64;
  typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_t;
endpackage

module theta_stage
  import keccak_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t state_array_in,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t state_array_out
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;

  occ_e   state_q, state_d;
  logic   in_ready_q;
  state_t out_q, skid_q, theta;
  logic [ROW_SIZE-1:0][LANE_SIZE-1:0] c, d;
  logic   accept, drain, load_out_theta, load_out_skid, load_skid;

  // Column parity, theta effect per column, then apply it to every lane
  for (genvar x = 0; x < ROW_SIZE; x++) begin : g_col
    always_comb begin
      c[x] = '0;
      for (int y = 0; y < COL_SIZE; y++) c[x] = c[x] ^ state_array_in[x][y];
    end
    assign d[x] = c[(x+4)%ROW_SIZE] ^
                  {c[(x+1)%ROW_SIZE][LANE_SIZE-2:0], c[(x+1)%ROW_SIZE][LANE_SIZE-1]};
    for (genvar y = 0; y < COL_SIZE; y++) begin : g_lane
      assign theta[x][y] = state_array_in[x][y] ^ d[x];
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = (state_q != EMPTY);
  assign state_array_out = out_q;
  assign accept          = in_valid && in_ready_q;
  assign drain           = out_valid && out_ready;

  // Occupancy next state and register load selects
  always_comb begin
    state_d        = state_q;
    load_out_theta = 1'b0;
    load_out_skid  = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: if (accept) begin
        state_d        = ONE;
        load_out_theta = 1'b1;
      end
      ONE: begin
        if (accept && drain) begin
          load_out_theta = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: if (drain) begin
        // in_ready is low here, so nothing new can arrive this cycle
        state_d       = ONE;
        load_out_skid = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, registered ready and data storage; reset discards everything held
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (load_out_theta)     out_q <= theta;
      else if (load_out_skid) out_q <= skid_q;
      if (load_skid) skid_q <= theta;
    end
  end

endmodule

// File: tb/tb_theta_stage.sv
// Directed bench for theta_stage: hand-computed single-bit and wrap cases,
// backpressure ordering, random streaming against a bitwise reference, reset.
module tb_theta_stage;
  import keccak_pkg::*;

  logic   clk = 1'b0;
  logic   rst, in_valid, in_ready, out_valid, out_ready;
  state_t state_array_in, state_array_out;
  state_t s1, s2, s3, exp_s, prev;
  int     total = 0;
  int     bad   = 0;

  theta_stage dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .state_array_in  (state_array_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .state_array_out (state_array_out)
  );

  always #5 clk = ~clk;

  // Bit-by-bit reference: A'[x][y][z] = A[x][y][z] ^ par(x-1, z) ^ par(x+1, z-1)
  function automatic state_t theta_ref(state_t a);
    state_t r;
    for (int x = 0; x < 5; x++)
      for (int z = 0; z < 64; z++) begin
        logic p;
        p = 1'b0;
        for (int y = 0; y < 5; y++)
          p = p ^ a[(x+4)%5][y][z] ^ a[(x+1)%5][y][(z+63)%64];
        for (int y = 0; y < 5; y++) r[x][y][z] = a[x][y][z] ^ p;
      end
    return r;
  endfunction

  function automatic state_t rand_state();
    state_t r;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) r[x][y] = {$urandom, $urandom};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_t obs, input state_t exp);
    int fx, fy;
    fx = -1; fy = -1;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        if (fx < 0 && obs[x][y] !== exp[x][y]) begin fx = x; fy = y; end
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s lane[%0d][%0d] observed=%h expected=%h", tag, fx, fy,
             obs[fx][fy], exp[fx][fy]);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; state_array_in = '0;
    step(); step();
    rst = 1'b0;
    chk_bit("reset_out_valid", out_valid, 1'b0);
    chk_bit("reset_in_ready", in_ready, 1'b1);
    chk_state("reset_data", state_array_out, '0);

    // Single bit at A[1][0] bit 0
    state_array_in = '0; state_array_in[1][0] = 64'h1;
    in_valid = 1'b1; out_ready = 1'b1;
    exp_s = '0;
    for (int y = 0; y < 5; y++) begin exp_s[0][y] = 64'h2; exp_s[2][y] = 64'h1; end
    exp_s[1][0] = 64'h1;
    step();
    chk_bit("single_valid", out_valid, 1'b1);
    chk_state("single_data", state_array_out, exp_s);
    in_valid = 1'b0;
    step();
    chk_bit("single_drained", out_valid, 1'b0);

    // All lanes one -> every lane 2
    for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) begin
      state_array_in[x][y] = 64'h1; exp_s[x][y] = 64'h2;
    end
    in_valid = 1'b1;
    step();
    chk_state("all_ones", state_array_out, exp_s);

    // Wrap of bit 63 through the rotate
    state_array_in = '0; state_array_in[1][0] = 64'h8000000000000000;
    exp_s = '0;
    for (int y = 0; y < 5; y++) begin
      exp_s[0][y] = 64'h1; exp_s[2][y] = 64'h8000000000000000;
    end
    exp_s[1][0] = 64'h8000000000000000;
    step();
    chk_state("wrap", state_array_out, exp_s);
    in_valid = 1'b0;
    step();
    chk_bit("wrap_drained", out_valid, 1'b0);

    // Backpressure: three back-to-back states, sink stalled
    s1 = rand_state(); s2 = rand_state(); s3 = rand_state();
    out_ready = 1'b0; in_valid = 1'b1; state_array_in = s1;
    step();
    chk_bit("bp_ready_after_1", in_ready, 1'b1);
    state_array_in = s2;
    step();
    chk_bit("bp_ready_after_2", in_ready, 1'b0);
    chk_state("bp_hold_s1_a", state_array_out, theta_ref(s1));
    state_array_in = s3;
    step();
    chk_bit("bp_still_full", in_ready, 1'b0);
    chk_state("bp_hold_s1_b", state_array_out, theta_ref(s1));
    out_ready = 1'b1;
    step();
    chk_bit("bp_ready_reopen", in_ready, 1'b1);
    chk_state("bp_out_s2", state_array_out, theta_ref(s2));
    step();
    in_valid = 1'b0;
    chk_state("bp_out_s3", state_array_out, theta_ref(s3));
    step();
    chk_bit("bp_empty", out_valid, 1'b0);

    // Streaming: one state per cycle with sink always ready
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prev = rand_state();
      state_array_in = prev;
      step();
      chk_bit("stream_valid", out_valid, 1'b1);
      chk_bit("stream_ready", in_ready, 1'b1);
      chk_state("stream_data", state_array_out, theta_ref(prev));
    end
    in_valid = 1'b0;
    step();
    chk_bit("stream_empty", out_valid, 1'b0);

    // Reset while FULL
    out_ready = 1'b0; in_valid = 1'b1;
    state_array_in = rand_state(); step();
    state_array_in = rand_state(); step();
    chk_bit("pre_reset_full", in_ready, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk_bit("rst_full_valid", out_valid, 1'b0);
    chk_bit("rst_full_ready", in_ready, 1'b1);
    chk_state("rst_full_data", state_array_out, '0);
    out_ready = 1'b1;
    step();
    chk_bit("rst_no_stale", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
